cache_mem_arbiter: RTL and testbench

- Shares the single external instruction/data memory port between the I-cache refill path and the single-word data-memory path of the CPU.
- Sequences I-cache line refills as LINE_WORDS-word bursts with a word counter.
- Performs D-side single-word reads and writes.
- Arbitrates simultaneous requests round-robin and saturation-counts completed refills for performance monitoring.

---
 rtl/cache_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one external memory port between I-cache line refills (LINE_WORDS-word bursts)
// and single-word D-side accesses, with round-robin tie-breaking and a refill counter.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [31:0]                   i_addr,
  output logic [31:0]                   i_rdata,
  output logic                          i_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] i_word,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [31:0]                   d_addr,
  input  logic [31:0]                   d_wdata,
  output logic [31:0]                   d_rdata,
  output logic                          d_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [CNT_W-1:0]              refill_cnt
);

  localparam int WW   = $clog2(LINE_WORDS);
  localparam int LB_W = 30 - WW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IFILL = 2'd1;
  localparam logic [1:0] S_DACC  = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [LB_W-1:0]  line_q, line_d;
  logic [29:0]      daddr_q, daddr_d;
  logic             dwe_q, dwe_d;
  logic [31:0]      dwdata_q, dwdata_d;
  logic [CNT_W-1:0] refill_q, refill_d;
  logic             take_i, take_d;

  // Offset bits of the request addresses carry no information for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1+WW:0], d_addr[1:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    line_d       = line_q;
    daddr_d      = daddr_q;
    dwe_d        = dwe_q;
    dwdata_d     = dwdata_q;
    refill_d     = refill_q;
    take_i       = 1'b0;
    take_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Round-robin pointer only moves on a genuine tie.
        if (i_req && d_req) begin
          take_d       = (last_grant_q == GNT_I);
          take_i       = (last_grant_q == GNT_D);
          last_grant_d = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
        end else begin
          take_d = d_req;
          take_i = i_req;
        end
        if (take_i) begin
          state_d = S_IFILL;
          line_d  = i_addr[31:2+WW];
          cnt_d   = '0;
        end
        if (take_d) begin
          state_d  = S_DACC;
          daddr_d  = d_addr[31:2];
          dwe_d    = d_we;
          dwdata_d = d_wdata;
        end
      end
      S_IFILL: begin
        if (mem_ready) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d    = '0;
            refill_d = sat_inc(refill_q);
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + WW'(1);
          end
        end
      end
      S_DACC: begin
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GNT_I;
      line_q       <= '0;
      daddr_q      <= '0;
      dwe_q        <= 1'b0;
      dwdata_q     <= '0;
      refill_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      line_q       <= line_d;
      daddr_q      <= daddr_d;
      dwe_q        <= dwe_d;
      dwdata_q     <= dwdata_d;
      refill_q     <= refill_d;
    end
  end

  // Done and data strobes are combinational with mem_ready inside the active state.
  always_comb begin
    i_rdata   = '0;
    i_rvalid  = 1'b0;
    i_word    = '0;
    i_done    = 1'b0;
    d_rdata   = '0;
    d_done    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IFILL: begin
        mem_req  = 1'b1;
        mem_addr = {line_q, cnt_q, 2'b00};
        if (mem_ready) begin
          i_rvalid = 1'b1;
          i_rdata  = mem_rdata;
          i_word   = cnt_q;
          i_done   = (cnt_q == LAST_WORD);
        end
      end
      S_DACC: begin
        mem_req   = 1'b1;
        mem_we    = dwe_q;
        mem_addr  = {daddr_q, 2'b00};
        mem_wdata = dwdata_q;
        if (mem_ready) begin
          d_done  = 1'b1;
          d_rdata = dwe_q ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign refill_cnt = refill_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus queues expected memory transfers,
// a negedge monitor pops and compares each completed transfer.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_rvalid, i_done, d_done, mem_req, mem_we, busy;
  logic [1:0]  i_word;
  logic [15:0] refill_cnt;

  logic [31:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2;
  logic        i_rvalid2, i_done2, d_done2, mem_req2, mem_we2, busy2;
  logic [1:0]  i_word2;
  logic [1:0]  refill_cnt2;

  // Memory model: word content depends on the word offset within a 16-byte line.
  assign mem_rdata = 32'hA0 + {30'd0, mem_addr[3:2]};

  cache_mem_arbiter #(.LINE_WORDS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .i_word(i_word), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .refill_cnt(refill_cnt)
  );

  cache_mem_arbiter #(.LINE_WORDS(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata2), .i_rvalid(i_rvalid2),
    .i_word(i_word2), .i_done(i_done2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata2), .d_done(d_done2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy2), .refill_cnt(refill_cnt2)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ivld;
    logic [1:0]  iword;
    logic [31:0] irdata;
    logic        idone;
    logic        ddone;
    logic [31:0] drdata;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_act, mon_exp;
  int    n_tests = 0;
  int    n_fail  = 0;

  always @(negedge clk) begin
    if (rst && mem_req && mem_ready) begin
      mon_act        = '0;
      mon_act.we     = mem_we;
      mon_act.addr   = mem_addr;
      mon_act.wdata  = mem_wdata;
      mon_act.ivld   = i_rvalid;
      mon_act.iword  = i_word;
      mon_act.irdata = i_rdata;
      mon_act.idone  = i_done;
      mon_act.ddone  = d_done;
      mon_act.drdata = d_rdata;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: addr=%h we=%b, no transfer expected", mem_addr, mem_we);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL xfer: got we=%b addr=%h wd=%h iv=%b iw=%0d ird=%h idn=%b ddn=%b drd=%h / expected we=%b addr=%h wd=%h iv=%b iw=%0d ird=%h idn=%b ddn=%b drd=%h",
                   mon_act.we, mon_act.addr, mon_act.wdata, mon_act.ivld, mon_act.iword,
                   mon_act.irdata, mon_act.idone, mon_act.ddone, mon_act.drdata,
                   mon_exp.we, mon_exp.addr, mon_exp.wdata, mon_exp.ivld, mon_exp.iword,
                   mon_exp.irdata, mon_exp.idone, mon_exp.ddone, mon_exp.drdata);
        end
      end
    end else if (rst && !mem_req) begin
      n_tests++;
      if ({i_rvalid, i_done, d_done} !== 3'b000 || i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL idle_strobes: got rv=%b idn=%b ddn=%b ird=%h drd=%h, expected all 0",
                 i_rvalid, i_done, d_done, i_rdata, d_rdata);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_refill(input logic [31:0] a, input int n);
    xfer_t r;
    for (int w = 0; w < n; w++) begin
      r        = '0;
      r.addr   = {a[31:4], 4'h0} + 32'(4 * w);
      r.ivld   = 1'b1;
      r.iword  = 2'(w);
      r.irdata = 32'hA0 + 32'(w);
      r.idone  = (w == 3);
      exp_q.push_back(r);
    end
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    xfer_t r;
    r        = '0;
    r.we     = we;
    r.addr   = {a[31:2], 2'b00};
    r.wdata  = wd;
    r.ddone  = 1'b1;
    r.drdata = we ? 32'd0 : 32'hA0 + 32'(a[3:2]);
    exp_q.push_back(r);
  endtask

  task automatic wait_done(input bit side_i, input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      seen = side_i ? i_done : d_done;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got no done, expected one within %0d cycles",
               side_i ? "i" : "d", budget);
    end
    step();
    if (side_i) i_req = 1'b0;
    else        d_req = 1'b0;
  endtask

  task automatic do_reset();
    i_req = 1'b0;
    d_req = 1'b0;
    rst   = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of stimulus, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int sat_exp[5] = '{1, 2, 3, 3, 3};

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0;
    step();

    // Reset held with live requests: nothing may move.
    i_req = 1'b1; i_addr = 32'h0000_1234; mem_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rst_mem_req",   32'(mem_req), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_i_rvalid",  32'(i_rvalid), 32'd0);
    chk("rst_refill_cnt", 32'(refill_cnt), 32'd0);

    // Release: refill of line 0x1230 at one word per cycle.
    push_refill(32'h0000_1234, 4);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_mem_req", 32'(mem_req), 32'd0);
    wait_done(1'b1, 10, cyc);
    chk("refill_cycles", 32'(cyc), 32'd4);
    chk("refill_cnt_1", 32'(refill_cnt), 32'd1);
    @(negedge clk);
    chk("refill_busy_after", 32'(busy), 32'd0);
    step();

    // D write with three stall cycles; request inputs change after grant.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0803; d_wdata = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    push_d(1'b1, 32'h0000_0803, 32'hDEAD_BEEF);
    step();
    d_addr = 32'h0000_0FFC; d_wdata = 32'h1234_5678; d_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_mem_addr",  mem_addr, 32'h0000_0800);
      chk("stall_mem_we",    32'(mem_we), 32'd1);
      chk("stall_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("stall_d_done",    32'(d_done), 32'd0);
      step();
    end
    mem_ready = 1'b1;
    wait_done(1'b0, 4, cyc);
    chk("dwrite_done_cycle", 32'(cyc), 32'd1);
    @(negedge clk);
    chk("dwrite_busy_after", 32'(busy), 32'd0);
    step();

    // D read: request-to-done is two cycles (IDLE, then DACC).
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0808; d_wdata = 32'h1111_2222;
    push_d(1'b0, 32'h0000_0808, 32'h1111_2222);
    wait_done(1'b0, 4, cyc);
    chk("dread_latency", 32'(cyc), 32'd2);

    // Tie after reset goes to D, then I after one IDLE cycle.
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_2000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; d_wdata = 32'd0;
    push_d(1'b0, 32'h0000_0040, 32'd0);
    push_refill(32'h0000_2000, 4);
    wait_done(1'b0, 4, cyc);
    chk("tie1_d_latency", 32'(cyc), 32'd2);
    @(negedge clk);
    chk("tie1_idle_gap", 32'(busy), 32'd0);
    wait_done(1'b1, 8, cyc);
    chk("tie1_i_cycles", 32'(cyc), 32'd4);
    @(negedge clk);
    chk("tie1_busy_after", 32'(busy), 32'd0);
    step();

    // Second tie goes to I.
    i_req = 1'b1; i_addr = 32'h0000_3000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0044; d_wdata = 32'hCAFE_F00D;
    push_refill(32'h0000_3000, 4);
    push_d(1'b1, 32'h0000_0044, 32'hCAFE_F00D);
    wait_done(1'b1, 8, cyc);
    chk("tie2_i_cycles", 32'(cyc), 32'd5);
    @(negedge clk);
    chk("tie2_idle_gap", 32'(busy), 32'd0);
    wait_done(1'b0, 4, cyc);
    chk("tie2_d_cycles", 32'(cyc), 32'd1);
    chk("tie_refill_cnt", 32'(refill_cnt), 32'd2);

    // Reset in the middle of a burst.
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_4000;
    push_refill(32'h0000_4000, 2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_mem_req",  32'(mem_req), 32'd0);
    chk("midrst_i_done",   32'(i_done), 32'd0);
    chk("midrst_busy",     32'(busy), 32'd0);
    chk("midrst_refill_cnt", 32'(refill_cnt), 32'd0);
    push_refill(32'h0000_4000, 4);
    @(posedge clk);
    step();
    rst = 1'b1;
    wait_done(1'b1, 8, cyc);
    chk("midrst_restart_cycles", 32'(cyc), 32'd5);
    chk("midrst_refill_cnt_after", 32'(refill_cnt), 32'd1);

    // Saturating counter on the CNT_W=2 instance.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      i_req = 1'b1; i_addr = 32'h0000_5000 + 32'(k * 16);
      push_refill(32'h0000_5000 + 32'(k * 16), 4);
      wait_done(1'b1, 8, cyc);
      @(negedge clk);
      chk("sat_refill_cnt2", 32'(refill_cnt2), 32'(sat_exp[k]));
      chk("sat_refill_cnt16", 32'(refill_cnt), 32'(k + 1));
      step();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
